fir_mac_filter: RTL



---
 rtl/fir_pkg.sv | 51 +++++
 rtl/fir_coef_bank.sv | 53 +++++
 rtl/fir_mac_filter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared encodings and Q-format helpers for the time-multiplexed FIR filter.
// Also holds the closed-form coefficient recipes used to build the fixed ROM banks.
package fir_pkg;

    localparam int DW_DEF   = 12;
    localparam int CW_DEF   = 16;
    localparam int TAPS_DEF = 31;

    typedef enum logic [1:0] {
        MODE_LPF  = 2'd0,
        MODE_HPF  = 2'd1,
        MODE_BPF  = 2'd2,
        MODE_USER = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Q2.(CW-2): fractional bit count and the half-LSB rounding constant.
    function automatic int q_frac(input int cw);
        return cw - 2;
    endfunction

    function automatic int rnd_const(input int cw);
        return 1 << (cw - 3);
    endfunction

    function automatic int box_coef(input int taps, input int cw);
        return ((1 << (cw - 2)) + taps / 2) / taps;
    endfunction

    // LPF is a unity-gain boxcar, HPF is delta minus boxcar, BPF is the boxcar modulated to fs/4.
    function automatic int fixed_coef(input mode_t m, input int k, input int taps, input int cw);
        int a;
        a = box_coef(taps, cw);
        case (m)
            MODE_LPF: return a;
            MODE_HPF: return ((k == 0) ? (1 << (cw - 2)) : 0) - a;
            MODE_BPF: begin
                if ((k % 4) == 0)      return 2 * a;
                else if ((k % 4) == 2) return -2 * a;
                else                   return 0;
            end
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient store: three fixed ROM banks plus one runtime-writable user bank.
// Read is combinational so the MAC can consume one coefficient per clock.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  mode_t                mode,
    input  logic [AW-1:0]        tap,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [CW-1:0] wr_data,
    output logic signed [CW-1:0] coef
);

    logic signed [CW-1:0] rom_lpf [TAPS];
    logic signed [CW-1:0] rom_hpf [TAPS];
    logic signed [CW-1:0] rom_bpf [TAPS];
    logic signed [CW-1:0] user    [TAPS];

    for (genvar i = 0; i < TAPS; i++) begin : g_rom
        assign rom_lpf[i] = CW'(fixed_coef(MODE_LPF, i, TAPS, CW));
        assign rom_hpf[i] = CW'(fixed_coef(MODE_HPF, i, TAPS, CW));
        assign rom_bpf[i] = CW'(fixed_coef(MODE_BPF, i, TAPS, CW));
    end

    // User bank comes out of reset as a passthrough (h[0] = 1.0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                user[i] <= (i == 0) ? CW'(1 << (CW - 2)) : '0;
            end
        end else if (wr_en && (int'(wr_addr) < TAPS)) begin
            user[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        coef = '0;
        case (mode)
            MODE_LPF:  coef = rom_lpf[tap];
            MODE_HPF:  coef = rom_hpf[tap];
            MODE_BPF:  coef = rom_bpf[tap];
            MODE_USER: coef = user[tap];
            default:   coef = '0;
        endcase
    end

endmodule

// File: rtl/fir_mac_filter.sv
// Mode-switchable FIR filter running one multiply-accumulate per clock per tap.
// A rising edge of the slow sample strobe captures a sample; the result appears TAPS+1 clocks later.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int ACC_W = DW + CW + $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       f_s,
    input  logic signed [DW-1:0]       din,
    input  logic [1:0]                 mode,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [CW-1:0]       coef_wdata,
    output logic signed [DW-1:0]       dout,
    output logic                       dout_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int AW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int QF = q_frac(CW);
    localparam logic signed [ACC_W:0] RND_EXT = (ACC_W + 1)'(rnd_const(CW));
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

    state_t                state;
    mode_t                 mode_q;
    logic                  f_s_d;
    logic                  rise;
    logic [AW-1:0]         wp;
    logic [AW-1:0]         newest;
    logic [AW-1:0]         k;
    logic [AW-1:0]         rd_idx;
    logic signed [DW-1:0]  x [TAPS];
    logic signed [CW-1:0]  coef;
    logic signed [PW-1:0]  prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0] acc_rnd;
    logic signed [ACC_W:0] acc_sh;
    logic signed [DW-1:0]  sat;

    assign rise = f_s & ~f_s_d;

    fir_coef_bank #(
        .CW   (CW),
        .TAPS (TAPS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode_q),
        .tap     (k),
        .wr_en   (coef_we & ~busy),
        .wr_addr (coef_addr),
        .wr_data (coef_wdata),
        .coef    (coef)
    );

    // Walk backwards from the newest sample through the circular delay line.
    always_comb begin
        rd_idx = '0;
        if (newest >= k) begin
            rd_idx = newest - k;
        end else begin
            rd_idx = AW'({1'b0, newest} + (AW + 1)'(TAPS) - {1'b0, k});
        end
    end

    assign prod = x[rd_idx] * coef;

    always_comb begin
        acc_rnd = {acc[ACC_W-1], acc} + RND_EXT;
        acc_sh  = acc_rnd >>> QF;
        if (acc_sh > OUT_MAX) begin
            sat = {1'b0, {(DW - 1){1'b1}}};
        end else if (acc_sh < OUT_MIN) begin
            sat = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            sat = acc_sh[DW-1:0];
        end
    end

    // Flush outranks everything, including a coincident sample edge, and never raises overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_LPF;
            f_s_d      <= 1'b1;
            wp         <= '0;
            newest     <= '0;
            k          <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            f_s_d      <= f_s;
            dout_valid <= 1'b0;
            if (flush) begin
                for (int i = 0; i < TAPS; i++) begin
                    x[i] <= '0;
                end
                acc   <= '0;
                wp    <= '0;
                k     <= '0;
                busy  <= 1'b0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            x[wp]  <= din;
                            newest <= wp;
                            wp     <= (wp == AW'(TAPS - 1)) ? '0 : wp + AW'(1);
                            mode_q <= mode_t'(mode);
                            acc    <= '0;
                            k      <= '0;
                            busy   <= 1'b1;
                            state  <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        if (rise) overrun <= 1'b1;
                        acc <= acc + ACC_W'(prod);
                        k   <= k + AW'(1);
                        if (k == AW'(TAPS - 1)) state <= ST_OUT;
                    end
                    ST_OUT: begin
                        if (rise) overrun <= 1'b1;
                        dout       <= sat;
                        dout_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
